// File: rtl/voice_phase_sequencer_pkg.sv
// Shared definitions for the voice phase sequencer: voice-word layout helpers and FSM encoding.
package voice_phase_sequencer_pkg;

    function automatic int word_w(input int ph_w, input int inc_w);
        return 1 + inc_w + ph_w;
    endfunction

    // Word layout: {gate, increment, phase}, phase in the LSBs.
    localparam int PHASE_LSB = 0;

    function automatic int inc_lsb(input int ph_w);
        return ph_w;
    endfunction

    function automatic int gate_bit(input int ph_w, input int inc_w);
        return ph_w + inc_w;
    endfunction

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_LAT   = 2'd2;
    localparam logic [1:0] ST_WB    = 2'd3;

endpackage

// File: rtl/voice_phase_sequencer_if.sv
// Sequencer-side bundle: voice RAM port, frame control and the phase stream to the mixer.
interface voice_phase_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int PH_W   = 24,
    parameter int INC_W  = 20
);
    localparam int WORD_W = 1 + INC_W + PH_W;

    logic              sample_tick;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [WORD_W-1:0] ram_din;
    logic [WORD_W-1:0] ram_dout;
    logic              phase_valid;
    logic [PH_W-1:0]   phase_out;
    logic [ADDR_W-1:0] voice_out;
    logic              gate_out;
    logic              frame_done;
    logic              busy;
    logic              overrun;
    logic              overrun_clr;

    modport master (
        input  sample_tick, ram_dout, overrun_clr,
        output ram_addr, ram_we, ram_din, phase_valid, phase_out,
               voice_out, gate_out, frame_done, busy, overrun
    );

    modport slave (
        output sample_tick, ram_dout, overrun_clr,
        input  ram_addr, ram_we, ram_din, phase_valid, phase_out,
               voice_out, gate_out, frame_done, busy, overrun
    );

endinterface

// File: rtl/voice_phase_step.sv
// Combinational voice update: advances phase by increment when gated, clears it otherwise.
// Gate and increment pass through unchanged; phase wraps modulo 2**PH_W.
module voice_phase_step
    import voice_phase_sequencer_pkg::*;
#(
    parameter int PH_W  = 24,
    parameter int INC_W = 20
) (
    input  logic [word_w(PH_W, INC_W)-1:0] word_i,
    output logic [word_w(PH_W, INC_W)-1:0] word_o
);
    localparam int INC_LSB  = inc_lsb(PH_W);
    localparam int GATE_BIT = gate_bit(PH_W, INC_W);

    logic             gate;
    logic [INC_W-1:0] inc;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  new_phase;

    always_comb begin
        gate      = word_i[GATE_BIT];
        inc       = word_i[INC_LSB +: INC_W];
        phase     = word_i[PHASE_LSB +: PH_W];
        new_phase = gate ? (phase + PH_W'(inc)) : '0;
        word_o    = {gate, inc, new_phase};
    end

endmodule

// File: rtl/voice_phase_sequencer.sv
// Per-tick read-modify-write sweep of all voice slots, 3 cycles per voice, all outputs registered.
// Ticks arriving mid-sweep are dropped and latched into the sticky overrun flag.
module voice_phase_sequencer
    import voice_phase_sequencer_pkg::*;
#(
    parameter int NUM_VOICES = 16,
    parameter int ADDR_W     = 4,
    parameter int PH_W       = 24,
    parameter int INC_W      = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    voice_phase_sequencer_if.master bus
);
    localparam int                WORD_W     = word_w(PH_W, INC_W);
    localparam int                GATE_BIT   = gate_bit(PH_W, INC_W);
    localparam logic [ADDR_W-1:0] LAST_VOICE = ADDR_W'(NUM_VOICES - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] voice_q, voice_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              pv_q, pv_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [ADDR_W-1:0] vout_q, vout_d;
    logic              gate_q, gate_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
    logic [WORD_W-1:0] step_word;

    voice_phase_step #(
        .PH_W  (PH_W),
        .INC_W (INC_W)
    ) u_step (
        .word_i (bus.ram_dout),
        .word_o (step_word)
    );

    always_comb begin
        state_d = state_q;
        voice_d = voice_q;
        we_d    = 1'b0;
        din_d   = din_q;
        pv_d    = 1'b0;
        phase_d = phase_q;
        vout_d  = vout_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        // Set wins over a same-cycle clear so no overrun is ever lost.
        ovr_d = bus.overrun_clr ? 1'b0 : ovr_q;
        if (bus.sample_tick && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.sample_tick) begin
                    voice_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_LAT;
            end
            ST_LAT: begin
                phase_d = bus.ram_dout[PHASE_LSB +: PH_W];
                gate_d  = bus.ram_dout[GATE_BIT];
                vout_d  = voice_q;
                pv_d    = 1'b1;
                din_d   = step_word;
                we_d    = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                if (voice_q == LAST_VOICE) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    voice_d = voice_q + ADDR_W'(1);
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            voice_q <= '0;
            we_q    <= 1'b0;
            din_q   <= '0;
            pv_q    <= 1'b0;
            phase_q <= '0;
            vout_q  <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            voice_q <= voice_d;
            we_q    <= we_d;
            din_q   <= din_d;
            pv_q    <= pv_d;
            phase_q <= phase_d;
            vout_q  <= vout_d;
            gate_q  <= gate_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    // The voice counter doubles as the RAM address, so the address is already registered.
    assign bus.ram_addr    = voice_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_din     = din_q;
    assign bus.phase_valid = pv_q;
    assign bus.phase_out   = phase_q;
    assign bus.voice_out   = vout_q;
    assign bus.gate_out    = gate_q;
    assign bus.frame_done  = done_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_voice_phase_sequencer.sv
// Directed bench for voice_phase_sequencer with a registered-read RAM model and a MIDI-side write port.
module tb_voice_phase_sequencer;
    localparam int NV = 16;
    localparam int AW = 4;
    localparam int PW = 24;
    localparam int IW = 20;
    localparam int WW = 1 + IW + PW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    voice_phase_sequencer_if #(.ADDR_W(AW), .PH_W(PW), .INC_W(IW)) bus();

    voice_phase_sequencer #(
        .NUM_VOICES (NV),
        .ADDR_W     (AW),
        .PH_W       (PW),
        .INC_W      (IW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WW-1:0] mem [0:NV-1];
    logic          midi_we   = 1'b0;
    logic [AW-1:0] midi_addr = '0;
    logic [WW-1:0] midi_din  = '0;
    logic          rand_dout = 1'b0;

    always @(posedge clk) begin
        if (midi_we) mem[midi_addr] <= midi_din;
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= rand_dout ? WW'({$urandom(), $urandom()}) : mem[bus.ram_addr];
    end

    logic          rec_pv    [0:63];
    logic [AW-1:0] rec_voice [0:63];
    logic [PW-1:0] rec_phase [0:63];
    logic          rec_gate  [0:63];
    logic          rec_done  [0:63];
    logic          rec_busy  [0:63];

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [WW-1:0] mkword(input logic g, input logic [IW-1:0] inc,
                                             input logic [PW-1:0] ph);
        return {g, inc, ph};
    endfunction

    task automatic load_slot(input int a, input logic [WW-1:0] w);
        midi_we   = 1'b1;
        midi_addr = AW'(a);
        midi_din  = w;
        @(negedge clk);
        midi_we   = 1'b0;
    endtask

    task automatic init_slots();
        for (int i = 0; i < NV; i++) begin
            load_slot(i, mkword(1'b1, IW'(i + 1), PW'(i * 4096)));
        end
    endtask

    // Record index n holds outputs registered at the n-th edge after the accepting edge.
    // Inputs driven while observing n are sampled at edge n+1.
    task automatic capture(input int tick_at, input int clr_at, input int ncyc);
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            rec_pv[n]    = bus.phase_valid;
            rec_voice[n] = bus.voice_out;
            rec_phase[n] = bus.phase_out;
            rec_gate[n]  = bus.gate_out;
            rec_done[n]  = bus.frame_done;
            rec_busy[n]  = bus.busy;
            bus.sample_tick = (n == tick_at);
            bus.overrun_clr = (n == clr_at);
            @(negedge clk);
        end
        bus.sample_tick = 1'b0;
        bus.overrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW+1+WW+1+PW+AW+1+1+1+1-1:0] outs;
        rst_n = 1'b0;
        rand_dout = 1'b1;
        bus.sample_tick = 1'b1;
        bus.overrun_clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            outs = {bus.ram_addr, bus.ram_we, bus.ram_din, bus.phase_valid, bus.phase_out,
                    bus.voice_out, bus.gate_out, bus.frame_done, bus.busy, bus.overrun};
            tests_run++;
            if (outs !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", c, outs);
            end
        end
        bus.sample_tick = 1'b0;
        rand_dout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int strobes;
        capture(-1, -1, 50);
        strobes = 0;
        for (int n = 0; n < 50; n++) begin
            logic exp_pv;
            exp_pv = (n >= 2) && (n <= 47) && (((n - 2) % 3) == 0);
            if (rec_pv[n]) strobes++;
            tests_run++;
            if (rec_pv[n] !== exp_pv) begin
                tests_failed++;
                $display("FAIL timing_pv n=%0d: got %b expected %b", n, rec_pv[n], exp_pv);
            end
            if (exp_pv) begin
                tests_run++;
                if (rec_voice[n] !== AW'((n - 2) / 3)) begin
                    tests_failed++;
                    $display("FAIL timing_voice n=%0d: got %0d expected %0d", n, rec_voice[n], (n - 2) / 3);
                end
            end
            tests_run++;
            if (rec_done[n] !== (n == 48)) begin
                tests_failed++;
                $display("FAIL timing_done n=%0d: got %b expected %b", n, rec_done[n], (n == 48));
            end
            tests_run++;
            if (rec_busy[n] !== (n <= 47)) begin
                tests_failed++;
                $display("FAIL timing_busy n=%0d: got %b expected %b", n, rec_busy[n], (n <= 47));
            end
        end
        tests_run++;
        if (strobes != NV) begin
            tests_failed++;
            $display("FAIL strobe_count: got %0d expected %0d", strobes, NV);
        end
    endtask

    task automatic test_accumulate();
        tests_run++;
        if (rec_phase[2] !== 24'h000100 || rec_voice[2] !== 4'd0 || rec_gate[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL slot0_strobe: got phase %h voice %0d gate %b expected 000100 0 1",
                     rec_phase[2], rec_voice[2], rec_gate[2]);
        end
        tests_run++;
        if (mem[0] !== mkword(1'b1, 20'h00010, 24'h000110)) begin
            tests_failed++;
            $display("FAIL slot0_writeback: got %h expected %h", mem[0], mkword(1'b1, 20'h00010, 24'h000110));
        end
    endtask

    task automatic test_wrap();
        tests_run++;
        if (rec_phase[11] !== 24'hFFFFF0) begin
            tests_failed++;
            $display("FAIL wrap_strobe: got %h expected fffff0", rec_phase[11]);
        end
        tests_run++;
        if (mem[3] !== mkword(1'b1, 20'h00020, 24'h000010)) begin
            tests_failed++;
            $display("FAIL wrap_writeback: got %h expected %h", mem[3], mkword(1'b1, 20'h00020, 24'h000010));
        end
    endtask

    task automatic test_gate_off();
        tests_run++;
        if (rec_phase[23] !== 24'h123456 || rec_gate[23] !== 1'b0 || rec_voice[23] !== 4'd7) begin
            tests_failed++;
            $display("FAIL gateoff_strobe: got phase %h gate %b voice %0d expected 123456 0 7",
                     rec_phase[23], rec_gate[23], rec_voice[23]);
        end
        tests_run++;
        if (mem[7] !== mkword(1'b0, 20'h01234, 24'h000000)) begin
            tests_failed++;
            $display("FAIL gateoff_writeback: got %h expected %h", mem[7], mkword(1'b0, 20'h01234, 24'h000000));
        end
    endtask

    task automatic test_second_tick();
        logic [WW-1:0] w;
        capture(-1, -1, 50);
        tests_run++;
        if (rec_phase[2] !== 24'h000110) begin
            tests_failed++;
            $display("FAIL second_tick_phase: got %h expected 000110", rec_phase[2]);
        end
        w = mem[0];
        tests_run++;
        if (w[PW-1:0] !== 24'h000120) begin
            tests_failed++;
            $display("FAIL second_tick_writeback: got %h expected 000120", w[PW-1:0]);
        end
        tests_run++;
        if (rec_phase[11] !== 24'h000010) begin
            tests_failed++;
            $display("FAIL second_tick_wrapped_slot: got %h expected 000010", rec_phase[11]);
        end
    endtask

    task automatic test_overrun();
        tests_run++;
        if (bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_initial: got %b expected 0", bus.overrun);
        end
        capture(20, -1, 50);
        tests_run++;
        if (bus.overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set: got %b expected 1", bus.overrun);
        end
        tests_run++;
        if (rec_done[48] !== 1'b1 || rec_done[47] !== 1'b0 || rec_busy[48] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_frame_done: got done47=%b done48=%b busy48=%b expected 0 1 0",
                     rec_done[47], rec_done[48], rec_busy[48]);
        end
        tests_run++;
        if (rec_pv[47] !== 1'b1 || rec_voice[47] !== 4'd15 || rec_pv[23] !== 1'b1 || rec_voice[23] !== 4'd7) begin
            tests_failed++;
            $display("FAIL overrun_sweep: got pv47=%b v47=%0d pv23=%b v23=%0d expected 1 15 1 7",
                     rec_pv[47], rec_voice[47], rec_pv[23], rec_voice[23]);
        end
        capture(10, 10, 50);
        tests_run++;
        if (bus.overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_set_and_clear: got %b expected 1", bus.overrun);
        end
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        #1;
        tests_run++;
        if (bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_clear: got %b expected 0", bus.overrun);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int waited;
        capture(48, -1, 56);
        tests_run++;
        if (rec_done[48] !== 1'b1 || rec_busy[48] !== 1'b0 || rec_busy[49] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_restart: got done48=%b busy48=%b busy49=%b expected 1 0 1",
                     rec_done[48], rec_busy[48], rec_busy[49]);
        end
        tests_run++;
        if (rec_pv[51] !== 1'b1 || rec_voice[51] !== 4'd0) begin
            tests_failed++;
            $display("FAIL b2b_first_strobe: got pv=%b voice=%0d expected 1 0", rec_pv[51], rec_voice[51]);
        end
        waited = 0;
        while (bus.busy === 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second_frame_end: got busy %b expected 0 within 60 cycles", bus.busy);
        end
        tests_run++;
        if (bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_no_overrun: got %b expected 0", bus.overrun);
        end
    endtask

    task automatic test_reset_mid_frame();
        init_slots();
        bus.sample_tick = 1'b1;
        @(negedge clk);
        bus.sample_tick = 1'b0;
        repeat (17) @(negedge clk);
        tests_run++;
        if (bus.ram_we !== 1'b1 || bus.voice_out !== 4'd5) begin
            tests_failed++;
            $display("FAIL midreset_position: got we=%b voice=%0d expected 1 5", bus.ram_we, bus.voice_out);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.ram_we !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: got we=%b busy=%b expected 0 0", bus.ram_we, bus.busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.phase_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_idle: got busy=%b pv=%b expected 0 0", bus.busy, bus.phase_valid);
        end
        for (int i = 0; i < NV; i++) begin
            logic [WW-1:0] exp_w;
            exp_w = (i < 5) ? mkword(1'b1, IW'(i + 1), PW'(i * 4096 + i + 1))
                            : mkword(1'b1, IW'(i + 1), PW'(i * 4096));
            tests_run++;
            if (mem[i] !== exp_w) begin
                tests_failed++;
                $display("FAIL midreset_slot%0d: got %h expected %h", i, mem[i], exp_w);
            end
        end
    endtask

    initial begin
        bus.sample_tick = 1'b0;
        bus.overrun_clr = 1'b0;
        @(negedge clk);
        test_reset();
        init_slots();
        load_slot(0, mkword(1'b1, 20'h00010, 24'h000100));
        load_slot(3, mkword(1'b1, 20'h00020, 24'hFFFFF0));
        load_slot(7, mkword(1'b0, 20'h01234, 24'h123456));
        test_single_frame();
        test_accumulate();
        test_wrap();
        test_gate_off();
        test_second_tick();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at 100000 ns");
        $fatal(1);
    end

endmodule
